// File: rtl/gray_bin_conv_pipe_if.sv
// Stream bundle for the Gray/binary converter: input handshake with
// per-word mode, output handshake with mode and adjacency flag.
interface gray_bin_conv_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_adj_err;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_adj_err
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_adj_err
    );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// Two-stage pipelined Gray<->binary converter with valid/ready backpressure,
// a Gray-domain adjacency monitor and a saturating adjacency-error counter.
module gray_bin_conv_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_bin_conv_pipe_if.slave  bus,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     err_count
);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    logic             s1_mode_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_mode_reg;
    logic             out_adj_err_reg;

    logic [WIDTH-1:0] prev_gray_reg;
    logic             hist_v_reg;
    logic [CNT_W-1:0] err_count_reg;

    logic             s1_adv;
    logic             s2_adv;
    logic             s2_load;
    logic [WIDTH-1:0] g2b;
    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] gw;
    logic [WIDTH-1:0] gdiff;
    logic             adj_err;

    // out_ready -> in_ready is the only combinational path through the block
    assign s2_adv       = !out_valid_reg || bus.out_ready;
    assign s1_adv       = !s1_valid_reg || s2_adv;
    assign s2_load      = s1_valid_reg && s2_adv;
    assign bus.in_ready = s1_adv;

    // Each binary bit is the XOR of all Gray bits at or above it
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign g2b[gi] = ^s1_data_reg[WIDTH-1:gi];
        end
    endgenerate

    assign b2g   = s1_data_reg ^ (s1_data_reg >> 1);
    assign conv  = s1_mode_reg ? b2g : g2b;
    assign gw    = s1_mode_reg ? b2g : s1_data_reg;
    assign gdiff = gw ^ prev_gray_reg;

    // More than one bit set <=> clearing the lowest set bit leaves a nonzero word
    assign adj_err = hist_v_reg && (|(gdiff & (gdiff - WIDTH'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mode_reg  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_reg <= bus.in_data;
                s1_mode_reg <= bus.in_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_mode_reg    <= 1'b0;
            out_adj_err_reg <= 1'b0;
            prev_gray_reg   <= '0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg    <= conv;
                out_mode_reg    <= s1_mode_reg;
                out_adj_err_reg <= adj_err;
                prev_gray_reg   <= gw;
            end
        end
    end

    // Clear wins over a coincident transfer: no increment, history forgotten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_v_reg    <= 1'b0;
            err_count_reg <= '0;
        end else if (clear_err) begin
            hist_v_reg    <= 1'b0;
            err_count_reg <= '0;
        end else if (s2_load) begin
            hist_v_reg <= 1'b1;
            if (adj_err && (err_count_reg != {CNT_W{1'b1}})) begin
                err_count_reg <= err_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_mode    = out_mode_reg;
    assign bus.out_adj_err = out_adj_err_reg;
    assign err_count       = err_count_reg;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed and randomized bench for gray_bin_conv_pipe, checked against a
// transaction-level reference model (queue of expected results).
module tb_gray_bin_conv_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear_err = 1'b0;
    logic [CNT_W-1:0] err_count;

    gray_bin_conv_pipe_if #(.WIDTH(WIDTH)) bus ();

    gray_bin_conv_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clear_err (clear_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             mode;
        logic             adj;
        int               cnt;
        int               acc;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               step_no = 0;
    bit               accepted;
    bit               lat_chk = 0;
    bit               clr_pend = 0;
    logic [WIDTH-1:0] m_prev = '0;
    bit               m_hv = 0;
    int               m_cnt = 0;
    bit               stall_prev = 0;
    logic [WIDTH-1:0] hold_data;
    logic             hold_mode;
    logic             hold_adj;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: Gray->binary as XOR of all right shifts, binary->Gray as b^(b>>1)
    function automatic void model_push(input logic [WIDTH-1:0] d, input logic m);
        exp_t             e;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] g;
        bit               err;
        if (!m) begin
            res = d;
            for (int s = 1; s < WIDTH; s++) res = res ^ (d >> s);
            g = d;
        end else begin
            res = d ^ (d >> 1);
            g = res;
        end
        err = m_hv && ($countones(g ^ m_prev) > 1);
        m_prev = g;
        m_hv = 1;
        if (clr_pend) begin
            m_hv = 0;
            m_cnt = 0;
            clr_pend = 0;
        end else if (err && m_cnt < CNT_MAX) begin
            m_cnt++;
        end
        e.data = res; e.mode = m; e.adj = err; e.cnt = m_cnt; e.acc = step_no;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_hv = 0;
        m_cnt = 0;
        m_prev = '0;
        stall_prev = 0;
        clr_pend = 0;
    endfunction

    // One clock: called at the falling edge with inputs already driven
    task automatic step();
        exp_t e;
        #1;
        if (stall_prev) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data", int'(bus.out_data), int'(hold_data));
            chk("stall_mode", int'(bus.out_mode), int'(hold_mode));
            chk("stall_adj", int'(bus.out_adj_err), int'(hold_adj));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", int'(bus.out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", int'(bus.out_data), int'(e.data));
                chk("out_mode", int'(bus.out_mode), int'(e.mode));
                chk("out_adj_err", int'(bus.out_adj_err), int'(e.adj));
                chk("err_count", int'(err_count), e.cnt);
                if (lat_chk) chk("latency", step_no - e.acc, 2);
                $display("t=%0t out data=%02h mode=%0d adj=%0d cnt=%0d",
                         $time, bus.out_data, bus.out_mode, bus.out_adj_err, err_count);
            end
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) model_push(bus.in_data, bus.in_mode);
        stall_prev = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_mode = bus.out_mode;
        hold_adj = bus.out_adj_err;
        @(posedge clk);
        @(negedge clk);
        step_no++;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic m);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_mode = m;
        accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) step();
        if (!accepted) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("drain_empty", exp_q.size(), 0);
        step();
    endtask

    task automatic idle_clear();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        m_hv = 0;
        m_cnt = 0;
        #1 chk("idle_clear", int'(err_count), 0);
    endtask

    logic [WIDTH-1:0] bp_words [5];
    logic [WIDTH-1:0] last_d;
    int               bp_idx;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", int'(bus.in_ready), 1);
        chk("idle_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);

        // Conversion values at full rate with latency check
        lat_chk = 1;
        send(8'hAA, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hCC, 1'b1);
        send(8'h00, 1'b0);
        drain();
        lat_chk = 0;

        // Backpressure: five words against a stalled sink
        bp_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bp_idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = bp_words[bp_idx];
            bus.in_mode = bp_idx[0];
            step();
            if (accepted) bp_idx++;
        end
        chk("bp_accepted", bp_idx, 2);
        #1 chk("bp_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        while (bp_idx < 5) begin
            send(bp_words[bp_idx], bp_idx[0]);
            bp_idx++;
        end
        drain();

        // Adjacency monitor
        idle_clear();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        drain();
        chk("adj_count", int'(err_count), 2);

        // Asynchronous reset mid-cycle with a stalled word on the output
        bus.out_ready = 1'b0;
        send(8'h12, 1'b0);
        step();
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(bus.out_valid), 0);
        chk("async_out_data", int'(bus.out_data), 0);
        chk("async_err_count", int'(err_count), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rel_in_ready", int'(bus.in_ready), 1);
        chk("rel_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);

        // Saturation, then clear coinciding with a transfer
        for (int i = 0; i < 6; i++) send(i[0] ? 8'hFF : 8'h00, 1'b0);
        drain();
        chk("sat_count", int'(err_count), CNT_MAX);
        clr_pend = 1;
        send(8'h00, 1'b0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        send(8'hFF, 1'b0);
        drain();
        chk("clr_count", int'(err_count), 0);

        // Reset with two words in flight
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        bus.in_mode = 1'b0;
        @(posedge clk);
        #1 bus.in_data = 8'hC3;
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1 chk("flight_rst_valid", int'(bus.out_valid), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("flight_no_out", int'(bus.out_valid), 0);
            step();
        end
        send(8'h5A, 1'b1);
        drain();

        // Randomized traffic with random backpressure
        last_d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom % 4) != 0;
            if ($urandom % 2) bus.in_data = last_d ^ WIDTH'(1 << ($urandom % WIDTH));
            else bus.in_data = WIDTH'($urandom);
            bus.in_mode = 1'(($urandom % 2));
            bus.out_ready = ($urandom % 3) != 0;
            step();
            if (accepted) last_d = bus.in_data;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
